seq_stream_checker: RTL and testbench

Receive-side checker for the 10-bit incrementing-word stream produced by our stimulus counters. It consumes one word per accepted beat and verifies that each word equals the previous word plus one, modulo 2^WIDTH. It reports lock status, mismatch pulses, a saturating error count and the last offending word. It sits at the sink end of any path that carries the counter stream, either the passthrough or a registered copy stage, and replaces manual `$display` inspection with checkable hardware flags.

---
 rtl/seq_stream_checker.sv | 110 +++++++++++
 tb/tb_seq_stream_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_checker.sv
// seq_stream_checker: sink-side checker for an incrementing-word counter stream
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   clear             synchronous restart to HUNT, zeroes err_count (beats ignored)
//   halt_on_error     a mismatch while LOCKED freezes the checker in HALTED
//   in_valid, in_data input word stream; a beat is accepted when in_valid && in_ready
//   in_ready          low only while HALTED (decoded from state register)
//   locked            high while LOCKED
//   err_pulse         one-cycle pulse per mismatch seen while LOCKED
//   err_count         saturating count of mismatches seen while LOCKED
//   last_bad          most recent mismatching word
//   expected          value the next word must equal
module seq_stream_checker #(
    parameter int WIDTH      = 10,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             halt_on_error,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_bad,
    output logic [WIDTH-1:0] expected
);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED, HALTED} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             accept, match;

    assign in_ready  = state_q != HALTED;
    assign locked    = state_q == LOCKED;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign last_bad  = last_bad_q;
    assign expected  = expected_q;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        last_bad_d  = last_bad_q;
        expected_d  = expected_q;
        accept      = in_valid && in_ready;
        match       = in_data == expected_q;
        if (clear) begin
            state_d     = HUNT;
            match_cnt_d = '0;
            err_count_d = '0;
        end else if (accept) begin
            // every accepted word resyncs the prediction, matching or not
            expected_d = in_data + WIDTH'(1);
            case (state_q)
                HUNT: begin
                    match_cnt_d = '0;
                    state_d     = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                end
                SYNC: begin
                    if (match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == MW'(LOCK_COUNT - 1)) state_d = LOCKED;
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_pulse_d = 1'b1;
                        err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
                        last_bad_d  = in_data;
                        if (halt_on_error) state_d = HALTED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            last_bad_q  <= '0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            last_bad_q  <= last_bad_d;
            expected_q  <= expected_d;
        end
    end
endmodule

// File: tb/tb_seq_stream_checker.sv
// tb_seq_stream_checker: vectors, corner sequences and randomized run against a reference model
module tb_seq_stream_checker;
    localparam int W    = 10;
    localparam int LC   = 4;
    localparam int EW   = 2;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          halt_on_error = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, locked, err_pulse;
    logic [EW-1:0] err_count;
    logic [W-1:0]  last_bad, expected;

    int tests = 0;
    int fails = 0;

    // reference model: mode 0=hunt 1=sync 2=locked 3=halted; run = words in sequence so far
    int m_mode, m_run, m_cnt, m_last, m_exp;
    bit m_pulse;

    seq_stream_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .halt_on_error(halt_on_error),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count), .last_bad(last_bad), .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_cnt = 0; m_last = 0; m_exp = 0; m_pulse = 0;
    endtask

    task automatic model(input logic c, input logic h, input logic v, input logic [W-1:0] d);
        bit hit;
        m_pulse = 0;
        if (c) begin
            m_mode = 0; m_run = 0; m_cnt = 0;
        end else if (v && m_mode != 3) begin
            hit = (int'(d) == m_exp);
            if (m_mode == 0) begin
                m_run = 1;
                m_mode = (m_run >= LC) ? 2 : 1;
            end else if (m_mode == 1) begin
                m_run = hit ? m_run + 1 : 1;
                if (m_run >= LC) m_mode = 2;
            end else if (!hit) begin
                m_pulse = 1;
                m_cnt = (m_cnt + 1 > EMAX) ? EMAX : m_cnt + 1;
                m_last = int'(d);
                if (h) m_mode = 3;
            end
            m_exp = (int'(d) + 1) % (1 << W);
        end
    endtask

    task automatic step(input logic c, input logic h, input logic v, input logic [W-1:0] d);
        clear = c; halt_on_error = h; in_valid = v; in_data = d;
        model(c, h, v, d);
        @(posedge clk); #1;
        chk("m_in_ready", 32'(in_ready), 32'(m_mode != 3));
        chk("m_locked", 32'(locked), 32'(m_mode == 2));
        chk("m_err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("m_err_count", 32'(err_count), 32'(m_cnt));
        chk("m_last_bad", 32'(last_bad), 32'(m_last));
        chk("m_expected", 32'(expected), 32'(m_exp));
    endtask

    typedef struct {
        logic c, h, v;
        logic [W-1:0] d;
        logic lk, pl, rdy;
        int cnt, last, expv;
    } vec_t;

    vec_t tbl[9];
    int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
    int sat_dat[6] = '{100, 200, 300, 400, 500, 600};

    initial begin
        //            c  h  v  data  lk pl rdy cnt last exp
        tbl[0] = '{1'b0, 1'b0, 1'b1, 10'd1020, 1'b0, 1'b0, 1'b1, 0, 0, 1021};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 10'd1021, 1'b0, 1'b0, 1'b1, 0, 0, 1022};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 10'd1022, 1'b0, 1'b0, 1'b1, 0, 0, 1023};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b1, 0, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 10'd0,    1'b1, 1'b0, 1'b1, 0, 0, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 10'd1,    1'b1, 1'b0, 1'b1, 0, 0, 2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 10'd2,    1'b1, 1'b0, 1'b1, 0, 0, 3};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 10'd5,    1'b1, 1'b0, 1'b1, 0, 0, 3};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 10'd3,    1'b0, 1'b0, 1'b1, 0, 0, 3};

        model_reset();
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_last_bad", 32'(last_bad), 0);
        chk("rst_expected", 32'(expected), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].c, tbl[i].h, tbl[i].v, tbl[i].d);
            chk("tbl_locked", 32'(locked), 32'(tbl[i].lk));
            chk("tbl_err_pulse", 32'(err_pulse), 32'(tbl[i].pl));
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].rdy));
            chk("tbl_err_count", 32'(err_count), 32'(tbl[i].cnt));
            chk("tbl_last_bad", 32'(last_bad), 32'(tbl[i].last));
            chk("tbl_expected", 32'(expected), 32'(tbl[i].expv));
        end

        // single error without halt
        for (int i = 5; i <= 8; i++) step(0, 0, 1, 10'(i));
        chk("se_locked", 32'(locked), 1);
        step(0, 0, 1, 10'd20);
        chk("se_pulse", 32'(err_pulse), 1);
        chk("se_count", 32'(err_count), 1);
        chk("se_last", 32'(last_bad), 20);
        chk("se_locked2", 32'(locked), 1);
        step(0, 0, 1, 10'd21);
        chk("se_nopulse", 32'(err_pulse), 0);
        chk("se_count2", 32'(err_count), 1);
        step(1, 0, 0, 10'd0);

        // halt on error, then recovery via clear
        for (int i = 5; i <= 8; i++) step(0, 1, 1, 10'(i));
        step(0, 1, 1, 10'd20);
        chk("h_ready", 32'(in_ready), 0);
        chk("h_pulse", 32'(err_pulse), 1);
        chk("h_locked", 32'(locked), 0);
        step(0, 1, 1, 10'd40);
        chk("h_ignored_cnt", 32'(err_count), 1);
        chk("h_ignored_pulse", 32'(err_pulse), 0);
        chk("h_hold_exp", 32'(expected), 21);
        step(1, 0, 0, 10'd0);
        chk("h_clr_ready", 32'(in_ready), 1);
        chk("h_clr_cnt", 32'(err_count), 0);
        chk("h_clr_locked", 32'(locked), 0);

        // mismatch while syncing restarts the run without counting an error
        step(0, 0, 1, 10'd3);
        step(0, 0, 1, 10'd4);
        step(0, 0, 1, 10'd9);
        chk("sy_nopulse", 32'(err_pulse), 0);
        step(0, 0, 1, 10'd10);
        step(0, 0, 1, 10'd11);
        chk("sy_notlocked", 32'(locked), 0);
        step(0, 0, 1, 10'd12);
        chk("sy_locked", 32'(locked), 1);
        chk("sy_count", 32'(err_count), 0);

        // saturation of the 2-bit error counter
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 10'(sat_dat[i]));
            chk("sat_count", 32'(err_count), 32'(sat_exp[i]));
            chk("sat_pulse", 32'(err_pulse), 1);
        end
        step(0, 0, 0, 10'd0);
        chk("sat_pulse_end", 32'(err_pulse), 0);

        // asynchronous reset between edges
        step(1, 0, 0, 10'd0);
        for (int i = 5; i <= 8; i++) step(0, 0, 1, 10'(i));
        step(0, 0, 1, 10'd50);
        step(0, 0, 1, 10'd60);
        chk("ar_pre_count", 32'(err_count), 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_locked", 32'(locked), 0);
        chk("ar_count", 32'(err_count), 0);
        chk("ar_last", 32'(last_bad), 0);
        model_reset();
        #1 rst = 1'b0;
        step(0, 0, 1, 10'd7);
        step(0, 0, 1, 10'd8);
        step(0, 0, 1, 10'd9);
        chk("ar_not_yet", 32'(locked), 0);
        step(0, 0, 1, 10'd10);
        chk("ar_relock", 32'(locked), 1);

        // randomized stream against the model
        for (int i = 0; i < 3000; i++) begin
            logic c, h, v;
            logic [W-1:0] d;
            c = $urandom_range(0, 49) == 0;
            h = $urandom_range(0, 2) == 0;
            v = $urandom_range(0, 3) != 0;
            d = ($urandom_range(0, 4) != 0) ? W'(m_exp) : W'($urandom);
            step(c, h, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
